// File: rtl/lu_arbiter_if.sv
// Bundle of requester, control and LU-side signals for lu_arbiter.
// The slave modport is the arbiter; the master modport is its environment (requesters plus LU).
interface lu_arbiter_if #(
  parameter int W = 8
);
  logic         en;
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [1:0]   s0;
  logic [1:0]   s1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [W-1:0] f;
  logic         busy;
  logic [W-1:0] lu_a;
  logic [W-1:0] lu_b;
  logic [1:0]   lu_s;
  logic [W-1:0] lu_f;

  modport slave (
    input  en, req0, req1, a0, b0, a1, b1, s0, s1, lu_f,
    output gnt0, gnt1, done0, done1, f, busy, lu_a, lu_b, lu_s
  );

  modport master (
    output en, req0, req1, a0, b0, a1, b1, s0, s1, lu_f,
    input  gnt0, gnt1, done0, done1, f, busy, lu_a, lu_b, lu_s
  );
endinterface

// File: rtl/lu_arbiter.sv
// Round-robin two-way arbiter and sequencer for a shared combinational logic unit.
// Every output is a register; an operation takes IDLE -> EXEC -> DONE.
module lu_arbiter #(
  parameter int W = 8
) (
  input logic         clk,
  input logic         rst,
  lu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic         last_q,  last_d;
  logic         own_q,   own_d;
  logic         gnt0_q,  gnt0_d;
  logic         gnt1_q,  gnt1_d;
  logic         done0_q, done0_d;
  logic         done1_q, done1_d;
  logic         busy_q,  busy_d;
  logic [W-1:0] f_q,     f_d;
  logic [W-1:0] lu_a_q,  lu_a_d;
  logic [W-1:0] lu_b_q,  lu_b_d;
  logic [1:0]   lu_s_q,  lu_s_d;
  logic         pick;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    own_d   = own_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    busy_d  = busy_q;
    f_d     = f_q;
    lu_a_d  = lu_a_q;
    lu_b_d  = lu_b_q;
    lu_s_d  = lu_s_q;
    // Contention goes to the requester that did not own the last grant.
    pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;

    unique case (state_q)
      IDLE: begin
        if (bus.en && (bus.req0 || bus.req1)) begin
          own_d   = pick;
          last_d  = pick;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          busy_d  = 1'b1;
          lu_a_d  = pick ? bus.a1 : bus.a0;
          lu_b_d  = pick ? bus.b1 : bus.b0;
          lu_s_d  = pick ? bus.s1 : bus.s0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        f_d     = bus.lu_f;
        done0_d = ~own_q;
        done1_d = own_q;
        state_d = DONE;
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      busy_q  <= 1'b0;
      f_q     <= '0;
      lu_a_q  <= '0;
      lu_b_q  <= '0;
      lu_s_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      own_q   <= own_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      busy_q  <= busy_d;
      f_q     <= f_d;
      lu_a_q  <= lu_a_d;
      lu_b_q  <= lu_b_d;
      lu_s_q  <= lu_s_d;
    end
  end

  assign bus.gnt0  = gnt0_q;
  assign bus.gnt1  = gnt1_q;
  assign bus.done0 = done0_q;
  assign bus.done1 = done1_q;
  assign bus.busy  = busy_q;
  assign bus.f     = f_q;
  assign bus.lu_a  = lu_a_q;
  assign bus.lu_b  = lu_b_q;
  assign bus.lu_s  = lu_s_q;

endmodule
